// File: rtl/coin_start_seq.sv
// coin_start_seq
// Conditions raw start/coin levels for the arcade core: each input is
// synchronised and debounced, and a rising debounced edge plays out a timed
// sequence of coin pulse(s), an idle gap, then the matching start pulse.
// Outputs are active-high; the top level inverts them into in0/in1.

module coin_start_seq #(
  parameter int unsigned DEBOUNCE    = 4096,
  parameter int unsigned COIN_PULSE  = 49152,
  parameter int unsigned COIN_GAP    = 49152,
  parameter int unsigned START_PULSE = 49152
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENA,
  input  logic I_START1,
  input  logic I_START2,
  input  logic I_COIN,
  output logic O_COIN,
  output logic O_START1,
  output logic O_START2,
  output logic O_BUSY
);

  // Channel order used throughout: 0 = start1, 1 = start2, 2 = coin.
  localparam int NCH = 3;
  localparam int CH_START1 = 0;
  localparam int CH_START2 = 1;
  localparam int CH_COIN   = 2;

  localparam logic [15:0] DEB_LIMIT   = 16'(DEBOUNCE);
  localparam logic [15:0] COIN_TICKS  = 16'(COIN_PULSE);
  localparam logic [15:0] GAP_TICKS   = 16'(COIN_GAP);
  localparam logic [15:0] START_TICKS = 16'(START_PULSE);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COIN,
    ST_GAP,
    ST_START,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_1P,
    SEL_2P
  } sel_t;

  logic [NCH-1:0] raw_in;
  logic [NCH-1:0] deb_level;
  logic [NCH-1:0] deb_rise;

  assign raw_in = {I_COIN, I_START2, I_START1};

  // ---------------------------------------------------------------------
  // Per-input conditioning: 2-flop synchroniser, debounce counter and a
  // delayed copy of the debounced level for rising-edge detection.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : gen_ch
      logic        sync1_reg;
      logic        sync2_reg;
      logic        deb_reg;
      logic        deb_d_reg;
      logic [15:0] deb_cnt_reg;

      // Synchronise, then accept a new level only after it has held for
      // DEB_LIMIT enabled ticks; any return to the accepted level restarts.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          sync1_reg   <= 1'b0;
          sync2_reg   <= 1'b0;
          deb_reg     <= 1'b0;
          deb_d_reg   <= 1'b0;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
          deb_d_reg <= deb_reg;
          if (sync2_reg == deb_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LIMIT) begin
            deb_reg     <= sync2_reg;
            deb_cnt_reg <= '0;
          end else if (ENA) begin
            deb_cnt_reg <= deb_cnt_reg + 16'd1;
          end
        end
      end

      assign deb_level[gi] = deb_reg;
      assign deb_rise[gi]  = deb_reg & ~deb_d_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  state_t      state_reg;
  sel_t        sel_reg;
  logic [1:0]  coins_reg;
  logic [15:0] tick_reg;
  logic        coin_out_reg;
  logic        start1_out_reg;
  logic        start2_out_reg;
  logic        tick_expire;

  // A phase ends on the enabled tick that would take the counter from 1 to 0,
  // so a load of N lasts exactly N enabled ticks.
  assign tick_expire = (tick_reg == 16'd1) && ENA;

  // Single-process FSM: every transition also sets the outputs for the state
  // being entered, so outputs change on the same edge as the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      sel_reg        <= SEL_NONE;
      coins_reg      <= 2'd0;
      tick_reg       <= '0;
      coin_out_reg   <= 1'b0;
      start1_out_reg <= 1'b0;
      start2_out_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // 2P has priority so simultaneous start edges give the 2P credit.
          if (deb_rise[CH_START2]) begin
            coins_reg      <= 2'd2;
            sel_reg        <= SEL_2P;
            state_reg      <= ST_COIN;
            tick_reg       <= COIN_TICKS;
            coin_out_reg   <= 1'b1;
            start1_out_reg <= 1'b0;
            start2_out_reg <= 1'b0;
          end else if (deb_rise[CH_START1]) begin
            coins_reg      <= 2'd1;
            sel_reg        <= SEL_1P;
            state_reg      <= ST_COIN;
            tick_reg       <= COIN_TICKS;
            coin_out_reg   <= 1'b1;
            start1_out_reg <= 1'b0;
            start2_out_reg <= 1'b0;
          end else if (deb_rise[CH_COIN]) begin
            coins_reg      <= 2'd1;
            sel_reg        <= SEL_NONE;
            state_reg      <= ST_COIN;
            tick_reg       <= COIN_TICKS;
            coin_out_reg   <= 1'b1;
            start1_out_reg <= 1'b0;
            start2_out_reg <= 1'b0;
          end
        end

        ST_COIN: begin
          if (tick_expire) begin
            coins_reg    <= coins_reg - 2'd1;
            state_reg    <= ST_GAP;
            tick_reg     <= GAP_TICKS;
            coin_out_reg <= 1'b0;
          end else if (ENA) begin
            tick_reg <= tick_reg - 16'd1;
          end
        end

        ST_GAP: begin
          if (tick_expire) begin
            if (coins_reg != 2'd0) begin
              state_reg    <= ST_COIN;
              tick_reg     <= COIN_TICKS;
              coin_out_reg <= 1'b1;
            end else if (sel_reg == SEL_1P) begin
              state_reg      <= ST_START;
              tick_reg       <= START_TICKS;
              start1_out_reg <= 1'b1;
            end else if (sel_reg == SEL_2P) begin
              state_reg      <= ST_START;
              tick_reg       <= START_TICKS;
              start2_out_reg <= 1'b1;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end else if (ENA) begin
            tick_reg <= tick_reg - 16'd1;
          end
        end

        ST_START: begin
          if (tick_expire) begin
            state_reg      <= ST_RELEASE;
            start1_out_reg <= 1'b0;
            start2_out_reg <= 1'b0;
          end else if (ENA) begin
            tick_reg <= tick_reg - 16'd1;
          end
        end

        ST_RELEASE: begin
          // Wait for every button to be let go so a held key cannot retrigger.
          if (deb_level == '0) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg      <= ST_IDLE;
          coin_out_reg   <= 1'b0;
          start1_out_reg <= 1'b0;
          start2_out_reg <= 1'b0;
        end
      endcase
    end
  end

  assign O_COIN   = coin_out_reg;
  assign O_START1 = start1_out_reg;
  assign O_START2 = start2_out_reg;
  assign O_BUSY   = (state_reg != ST_IDLE);

endmodule
